// File: rtl/counter_pkg.sv
// counter_pkg: shared digit width, seven-segment glyphs and default count range.
package counter_pkg;
    localparam int DIGIT_W = 4;
    localparam int DEF_MIN_COUNT = 1;
    localparam int DEF_MAX_COUNT = 99;
    // Active-high glyphs, bit0=a .. bit6=g
    localparam logic [6:0] SEG_GLYPH [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to seven-segment pattern, blank for 10-15.
module seg7_decode
    import counter_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [6:0]         o_seg
);
    logic [6:0] w_seg;
    assign w_seg = (i_digit <= 4'd9) ? SEG_GLYPH[i_digit] : SEG_BLANK;
    assign o_seg = ACTIVE_LOW ? ~w_seg : w_seg;
endmodule

// File: rtl/tick_bcd_counter.sv
// tick_bcd_counter: synchronises the divided clock, turns each rising edge into a
// one-cycle enable, and steps a wrapping two-digit BCD counter shown on two displays.
module tick_bcd_counter
    import counter_pkg::*;
#(
    parameter int MIN_COUNT      = DEF_MIN_COUNT,
    parameter int MAX_COUNT      = DEF_MAX_COUNT,
    parameter bit HEX_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_in,
    input  logic               run,
    input  logic               dir,
    input  logic               clear,
    output logic [DIGIT_W-1:0] ones,
    output logic [DIGIT_W-1:0] tens,
    output logic               tick_pulse,
    output logic               wrap,
    output logic [6:0]         hex0,
    output logic [6:0]         hex1
);
    localparam logic [DIGIT_W-1:0] MIN_T = DIGIT_W'(MIN_COUNT / 10);
    localparam logic [DIGIT_W-1:0] MIN_O = DIGIT_W'(MIN_COUNT % 10);
    localparam logic [DIGIT_W-1:0] MAX_T = DIGIT_W'(MAX_COUNT / 10);
    localparam logic [DIGIT_W-1:0] MAX_O = DIGIT_W'(MAX_COUNT % 10);

    logic               r_sync1, r_sync2, r_prev;
    logic               r_pulse, r_wrap;
    logic [DIGIT_W-1:0] r_ones, r_tens;
    logic               w_edge, w_at_min, w_at_max;

    // Sync stages reset high so a level already high at release is not an edge
    assign w_edge   = r_sync2 & ~r_prev;
    assign w_at_min = (r_tens == MIN_T) && (r_ones == MIN_O);
    assign w_at_max = (r_tens == MAX_T) && (r_ones == MAX_O);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_pulse <= 1'b0;
            r_wrap  <= 1'b0;
            r_ones  <= MIN_O;
            r_tens  <= MIN_T;
        end else begin
            r_sync1 <= tick_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pulse <= w_edge;
            r_wrap  <= 1'b0;
            if (clear) begin
                r_ones <= MIN_O;
                r_tens <= MIN_T;
            end else if (w_edge && run) begin
                if (dir) begin
                    if (w_at_max) begin
                        r_ones <= MIN_O;
                        r_tens <= MIN_T;
                        r_wrap <= 1'b1;
                    end else if (r_ones == 4'd9) begin
                        r_ones <= 4'd0;
                        r_tens <= r_tens + 4'd1;
                    end else begin
                        r_ones <= r_ones + 4'd1;
                    end
                end else begin
                    if (w_at_min) begin
                        r_ones <= MAX_O;
                        r_tens <= MAX_T;
                        r_wrap <= 1'b1;
                    end else if (r_ones == 4'd0) begin
                        r_ones <= 4'd9;
                        r_tens <= r_tens - 4'd1;
                    end else begin
                        r_ones <= r_ones - 4'd1;
                    end
                end
            end
        end
    end

    assign ones       = r_ones;
    assign tens       = r_tens;
    assign tick_pulse = r_pulse;
    assign wrap       = r_wrap;

    seg7_decode #(.ACTIVE_LOW(HEX_ACTIVE_LOW)) u_hex0 (.i_digit(r_ones), .o_seg(hex0));
    seg7_decode #(.ACTIVE_LOW(HEX_ACTIVE_LOW)) u_hex1 (.i_digit(r_tens), .o_seg(hex1));
endmodule

// File: tb/tb_tick_bcd_counter.sv
// tb_tick_bcd_counter: random and directed stimulus against a binary-count reference model.
module tb_tick_bcd_counter;
    localparam int MINC = 1;
    localparam int MAXC = 99;

    logic       clk = 1'b0;
    logic       reset, tick_in, run, dir, clear;
    logic [3:0] ones, tens;
    logic       tick_pulse, wrap;
    logic [6:0] hex0, hex1;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    int wrap_cnt = 0;

    // Active-low glyphs for 0..9
    logic [6:0] glyph_al [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    always #5 clk = ~clk;

    tick_bcd_counter dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .run(run), .dir(dir),
        .clear(clear), .ones(ones), .tens(tens), .tick_pulse(tick_pulse),
        .wrap(wrap), .hex0(hex0), .hex1(hex1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: binary count, tick_in sample history (newest first)
    int m_cnt = MINC;
    bit m_pulse = 0;
    bit m_wrap = 0;
    bit hist[$];

    always @(posedge clk) begin
        if (reset) begin
            hist = '{1'b1, 1'b1, 1'b1, 1'b1};
            m_cnt = MINC;
            m_pulse = 0;
            m_wrap = 0;
        end else begin
            hist.push_front(tick_in);
            void'(hist.pop_back());
            m_pulse = hist[2] && !hist[3];
            m_wrap = 0;
            if (clear) m_cnt = MINC;
            else if (m_pulse && run) begin
                if (dir) begin
                    if (m_cnt == MAXC) begin m_cnt = MINC; m_wrap = 1; end
                    else m_cnt = m_cnt + 1;
                end else begin
                    if (m_cnt == MINC) begin m_cnt = MAXC; m_wrap = 1; end
                    else m_cnt = m_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("ones", 32'(ones), 32'(m_cnt % 10));
        check("tens", 32'(tens), 32'(m_cnt / 10));
        check("tick_pulse", 32'(tick_pulse), 32'(m_pulse));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("hex0", 32'(hex0), 32'(glyph_al[m_cnt % 10]));
        check("hex1", 32'(hex1), 32'(glyph_al[m_cnt / 10]));
        if (tick_pulse) pulse_cnt++;
        if (wrap) wrap_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_tick();
        tick_in = 1'b0;
        cyc(4);
        tick_in = 1'b1;
        cyc(4);
    endtask

    logic [3:0] lat;

    initial begin
        reset = 1'b1; tick_in = 1'b1; run = 1'b1; dir = 1'b1; clear = 1'b0;
        cyc(3);
        reset = 1'b0;
        pulse_cnt = 0;
        cyc(10);
        check("rst_ones", 32'(ones), 32'd1);
        check("rst_tens", 32'(tens), 32'd0);
        check("rst_no_pulse", 32'(pulse_cnt), 32'd0);
        check("rst_hex0", 32'(hex0), 32'(7'b1111001));
        check("rst_hex1", 32'(hex1), 32'(7'b1000000));

        // Rise half a cycle before edge N; pulse expected only after edge N+2
        tick_in = 1'b0;
        cyc(5);
        tick_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #2;
            lat[k] = tick_pulse;
        end
        check("latency", 32'(lat), 32'(4'b0100));
        cyc(1);
        check("first_step", 32'({tens, ones}), 32'(8'h02));

        for (int i = 0; i < 7; i++) do_tick();
        check("at_09", 32'({tens, ones}), 32'(8'h09));
        do_tick();
        check("carry_10", 32'({tens, ones}), 32'(8'h10));
        for (int i = 0; i < 89; i++) do_tick();
        check("at_99", 32'({tens, ones}), 32'(8'h99));
        wrap_cnt = 0;
        do_tick();
        check("wrap_up_val", 32'({tens, ones}), 32'(8'h01));
        check("wrap_up_pulse", 32'(wrap_cnt), 32'd1);

        dir = 1'b0;
        wrap_cnt = 0;
        do_tick();
        check("wrap_dn_val", 32'({tens, ones}), 32'(8'h99));
        check("wrap_dn_pulse", 32'(wrap_cnt), 32'd1);
        do_tick();
        check("dn_98", 32'({tens, ones}), 32'(8'h98));
        check("dn_no_wrap", 32'(wrap_cnt), 32'd1);

        run = 1'b0;
        pulse_cnt = 0;
        for (int i = 0; i < 4; i++) do_tick();
        check("hold_pulses", 32'(pulse_cnt), 32'd4);
        check("hold_val", 32'({tens, ones}), 32'(8'h98));

        run = 1'b1;
        tick_in = 1'b0;
        cyc(4);
        tick_in = 1'b1;
        cyc(2);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        check("clr_pulse", 32'(tick_pulse), 32'd1);
        check("clr_wrap", 32'(wrap), 32'd0);
        check("clr_val", 32'({tens, ones}), 32'(8'h01));
        cyc(2);

        dir = 1'b1;
        do_tick();
        tick_in = 1'b0;
        cyc(4);
        tick_in = 1'b1;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        pulse_cnt = 0;
        cyc(6);
        check("rst_inflight_pulse", 32'(pulse_cnt), 32'd0);
        check("rst_inflight_val", 32'({tens, ones}), 32'(8'h01));

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) tick_in = ~tick_in;
            if ($urandom_range(0, 30) == 0) run = ~run;
            if ($urandom_range(0, 50) == 0) dir = ~dir;
            clear = ($urandom_range(0, 60) == 0);
            reset = ($urandom_range(0, 400) == 0);
            cyc(1);
        end
        reset = 1'b0; clear = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
